// File: rtl/pipelined_mips_cpu.sv
// Five-stage pipelined MIPS-subset CPU (IF/ID/EX/MEM/WB) with a hazard unit, an optional
// EX forwarding unit, a built-in program ROM, a register file and a word-addressed data memory.
// Retire/stall/flush ports exist only so a bench can watch the pipeline.
module pipelined_mips_cpu #(
  parameter logic [31:0] PC_RESET   = 32'h0,
  parameter bit          FORWARD_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] pc_o,
  output logic        retire_valid_o,
  output logic [31:0] retire_pc_o,
  output logic        stall_o,
  output logic        flush_o
);

  typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluSlt, AluSll, AluSrl, AluLui} alu_op_e;
  typedef enum logic [2:0] {BrEq, BrNe, BrLez, BrGez, BrLtz} br_type_e;

  typedef struct packed {
    logic     reg_write;
    logic     mem_read;
    logic     mem_write;
    logic     mem_to_reg;
    logic     alu_src;
    logic     branch;
    logic     jump;
    logic     link;
    br_type_e br_type;
    alu_op_e  alu_op;
  } ctrl_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    ctrl_t       ctrl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [4:0]  shamt;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
  } idex_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        reg_write;
    logic        mem_write;
    logic        mem_to_reg;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] store;
  } exmem_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        reg_write;
    logic [4:0]  dest;
    logic [31:0] data;
  } memwb_t;

  logic [31:0] pc_q, pc_d;
  ifid_t       ifid_q, ifid_d;
  idex_t       idex_q, idex_d;
  exmem_t      exmem_q, exmem_d;
  memwb_t      memwb_q, memwb_d;

  logic [31:0] rf_q [32];
  logic [31:0] dm_q [64];

  logic [31:0] if_instr;

  logic [5:0]  id_op, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt, id_dest;
  logic [31:0] id_imm, id_rs_val, id_rt_val, id_pc4, jump_target;
  ctrl_t       id_ctrl;
  logic        wb_we;

  logic        load_use, raw_ex, raw_mem, stall_req, stall, jump_redirect;

  logic [31:0] ex_a, ex_rt_fwd, ex_alu_b, ex_alu_y, ex_result, br_target;
  logic        br_cond, branch_taken;

  logic [31:0] dm_rdata;
  logic        unused_bits;

  // Built-in program ROM, indexed by word address
  always_comb begin
    if_instr = 32'h0000_0000;
    case (pc_q[9:2])
      8'h00: if_instr = 32'h2001_0005;  // addi $1,$0,5
      8'h01: if_instr = 32'h2022_0003;  // addi $2,$1,3
      8'h02: if_instr = 32'h0022_1820;  // add  $3,$1,$2
      8'h03: if_instr = 32'h2007_0007;  // addi $7,$0,7
      8'h04: if_instr = 32'hAC07_0000;  // sw   $7,0($0)
      8'h05: if_instr = 32'h8C04_0000;  // lw   $4,0($0)
      8'h06: if_instr = 32'h0084_2820;  // add  $5,$4,$4
      8'h07: if_instr = 32'h1000_0002;  // beq  $0,$0,+2
      8'h08: if_instr = 32'h2008_0001;  // addi $8,$0,1
      8'h09: if_instr = 32'h2009_0001;  // addi $9,$0,1
      8'h0A: if_instr = 32'h200A_0003;  // addi $10,$0,3
      8'h0B: if_instr = 32'h0800_0040;  // j    0x100
      8'h0C: if_instr = 32'h2006_0001;  // addi $6,$0,1
      8'h40: if_instr = 32'h200B_0009;  // addi $11,$0,9
      8'h41: if_instr = 32'hAC0B_0000;  // sw   $11,0($0)
      8'h42: if_instr = 32'h296C_000A;  // slti $12,$11,10
      8'h43: if_instr = 32'h0C00_0045;  // jal  0x114
      8'h44: if_instr = 32'h200D_0001;  // addi $13,$0,1
      8'h45: if_instr = 32'h1180_0004;  // beq  $12,$0,+4
      8'h46: if_instr = 32'h1580_0001;  // bne  $12,$0,+1
      8'h47: if_instr = 32'h200E_0001;  // addi $14,$0,1
      8'h48: if_instr = 32'h3C0F_1234;  // lui  $15,0x1234
      8'h49: if_instr = 32'h0800_0049;  // j    self
      default: if_instr = 32'h0000_0000;
    endcase
  end

  assign id_op       = ifid_q.instr[31:26];
  assign id_rs       = ifid_q.instr[25:21];
  assign id_rt       = ifid_q.instr[20:16];
  assign id_rd       = ifid_q.instr[15:11];
  assign id_shamt    = ifid_q.instr[10:6];
  assign id_funct    = ifid_q.instr[5:0];
  assign id_imm      = {{16{ifid_q.instr[15]}}, ifid_q.instr[15:0]};
  assign id_pc4      = ifid_q.pc + 32'd4;
  assign jump_target = {id_pc4[31:28], ifid_q.instr[25:0], 2'b00};

  // Decoder plus ALU control: opcode/funct to control fields and destination register
  always_comb begin
    id_ctrl = '0;
    id_dest = id_rt;
    case (id_op)
      6'h00: begin
        id_ctrl.reg_write = 1'b1;
        id_dest           = id_rd;
        case (id_funct)
          6'h20:   id_ctrl.alu_op = AluAdd;
          6'h22:   id_ctrl.alu_op = AluSub;
          6'h24:   id_ctrl.alu_op = AluAnd;
          6'h25:   id_ctrl.alu_op = AluOr;
          6'h2A:   id_ctrl.alu_op = AluSlt;
          6'h00:   id_ctrl.alu_op = AluSll;
          6'h02:   id_ctrl.alu_op = AluSrl;
          default: id_ctrl.reg_write = 1'b0;
        endcase
      end
      6'h08: begin
        id_ctrl.reg_write = 1'b1;
        id_ctrl.alu_src   = 1'b1;
      end
      6'h0A: begin
        id_ctrl.reg_write = 1'b1;
        id_ctrl.alu_src   = 1'b1;
        id_ctrl.alu_op    = AluSlt;
      end
      6'h0F: begin
        id_ctrl.reg_write = 1'b1;
        id_ctrl.alu_src   = 1'b1;
        id_ctrl.alu_op    = AluLui;
      end
      6'h23: begin
        id_ctrl.reg_write  = 1'b1;
        id_ctrl.mem_read   = 1'b1;
        id_ctrl.mem_to_reg = 1'b1;
        id_ctrl.alu_src    = 1'b1;
      end
      6'h2B: begin
        id_ctrl.mem_write = 1'b1;
        id_ctrl.alu_src   = 1'b1;
      end
      6'h04: id_ctrl.branch = 1'b1;
      6'h05: begin
        id_ctrl.branch  = 1'b1;
        id_ctrl.br_type = BrNe;
      end
      6'h06: begin
        id_ctrl.branch  = 1'b1;
        id_ctrl.br_type = BrLez;
      end
      6'h01: begin
        // REGIMM: rt=1 is bgez, rt=0 is bltz
        id_ctrl.branch  = 1'b1;
        id_ctrl.br_type = id_rt[0] ? BrGez : BrLtz;
      end
      6'h02: id_ctrl.jump = 1'b1;
      6'h03: begin
        id_ctrl.jump      = 1'b1;
        id_ctrl.link      = 1'b1;
        id_ctrl.reg_write = 1'b1;
        id_dest           = 5'd31;
      end
      default: id_ctrl = '0;
    endcase
  end

  assign wb_we = memwb_q.valid && memwb_q.reg_write && (memwb_q.dest != 5'd0);

  // Register file read with write-before-read bypass from WB
  always_comb begin
    id_rs_val = rf_q[id_rs];
    id_rt_val = rf_q[id_rt];
    if (wb_we && (memwb_q.dest == id_rs)) id_rs_val = memwb_q.data;
    if (wb_we && (memwb_q.dest == id_rt)) id_rt_val = memwb_q.data;
  end

  // EX: operand forwarding, ALU and branch resolution
  always_comb begin
    ex_a      = idex_q.rs_val;
    ex_rt_fwd = idex_q.rt_val;
    if (FORWARD_EN) begin
      if (exmem_q.reg_write && (exmem_q.dest != 5'd0) && (exmem_q.dest == idex_q.rs)) begin
        ex_a = exmem_q.result;
      end else if (memwb_q.reg_write && (memwb_q.dest != 5'd0) &&
                   (memwb_q.dest == idex_q.rs)) begin
        ex_a = memwb_q.data;
      end
      if (exmem_q.reg_write && (exmem_q.dest != 5'd0) && (exmem_q.dest == idex_q.rt)) begin
        ex_rt_fwd = exmem_q.result;
      end else if (memwb_q.reg_write && (memwb_q.dest != 5'd0) &&
                   (memwb_q.dest == idex_q.rt)) begin
        ex_rt_fwd = memwb_q.data;
      end
    end
    ex_alu_b = idex_q.ctrl.alu_src ? idex_q.imm : ex_rt_fwd;

    case (idex_q.ctrl.alu_op)
      AluAdd:  ex_alu_y = ex_a + ex_alu_b;
      AluSub:  ex_alu_y = ex_a - ex_alu_b;
      AluAnd:  ex_alu_y = ex_a & ex_alu_b;
      AluOr:   ex_alu_y = ex_a | ex_alu_b;
      AluSlt:  ex_alu_y = {31'h0, $signed(ex_a) < $signed(ex_alu_b)};
      AluSll:  ex_alu_y = ex_alu_b << idex_q.shamt;
      AluSrl:  ex_alu_y = ex_alu_b >> idex_q.shamt;
      AluLui:  ex_alu_y = {ex_alu_b[15:0], 16'h0};
      default: ex_alu_y = ex_a + ex_alu_b;
    endcase
    ex_result = idex_q.ctrl.link ? (idex_q.pc + 32'd4) : ex_alu_y;

    case (idex_q.ctrl.br_type)
      BrEq:    br_cond = (ex_a == ex_rt_fwd);
      BrNe:    br_cond = (ex_a != ex_rt_fwd);
      BrLez:   br_cond = ex_a[31] || (ex_a == 32'h0);
      BrGez:   br_cond = !ex_a[31];
      BrLtz:   br_cond = ex_a[31];
      default: br_cond = 1'b0;
    endcase
    branch_taken = idex_q.valid && idex_q.ctrl.branch && br_cond;
    br_target    = idex_q.pc + 32'd4 + {idex_q.imm[29:0], 2'b00};
  end

  // Hazard unit: load-use (or any RAW without forwarding) stall; taken branch overrides stall
  always_comb begin
    load_use = ifid_q.valid && idex_q.valid && idex_q.ctrl.mem_read &&
               ((idex_q.dest == id_rs) || (idex_q.dest == id_rt));
    raw_ex   = idex_q.valid && idex_q.ctrl.reg_write && (idex_q.dest != 5'd0) &&
               ((idex_q.dest == id_rs) || (idex_q.dest == id_rt));
    raw_mem  = exmem_q.valid && exmem_q.reg_write && (exmem_q.dest != 5'd0) &&
               ((exmem_q.dest == id_rs) || (exmem_q.dest == id_rt));
    stall_req     = FORWARD_EN ? load_use : (ifid_q.valid && (raw_ex || raw_mem));
    stall         = stall_req && !branch_taken;
    jump_redirect = ifid_q.valid && id_ctrl.jump && !stall && !branch_taken;
  end

  assign dm_rdata = dm_q[exmem_q.result[7:2]];

  // Next-state for PC and every pipeline register
  always_comb begin
    pc_d         = pc_q + 32'd4;
    ifid_d.valid = 1'b1;
    ifid_d.pc    = pc_q;
    ifid_d.instr = if_instr;
    if (branch_taken) begin
      pc_d   = br_target;
      ifid_d = '0;
    end else if (stall) begin
      pc_d   = pc_q;
      ifid_d = ifid_q;
    end else if (jump_redirect) begin
      pc_d   = jump_target;
      ifid_d = '0;
    end

    idex_d.valid  = ifid_q.valid;
    idex_d.pc     = ifid_q.pc;
    idex_d.ctrl   = ifid_q.valid ? id_ctrl : '0;
    idex_d.rs     = id_rs;
    idex_d.rt     = id_rt;
    idex_d.dest   = id_dest;
    idex_d.shamt  = id_shamt;
    idex_d.rs_val = id_rs_val;
    idex_d.rt_val = id_rt_val;
    idex_d.imm    = id_imm;
    if (branch_taken || stall) idex_d = '0;

    exmem_d.valid      = idex_q.valid;
    exmem_d.pc         = idex_q.pc;
    exmem_d.reg_write  = idex_q.ctrl.reg_write;
    exmem_d.mem_write  = idex_q.ctrl.mem_write;
    exmem_d.mem_to_reg = idex_q.ctrl.mem_to_reg;
    exmem_d.dest       = idex_q.dest;
    exmem_d.result     = ex_result;
    exmem_d.store      = ex_rt_fwd;

    memwb_d.valid     = exmem_q.valid;
    memwb_d.pc        = exmem_q.pc;
    memwb_d.reg_write = exmem_q.reg_write;
    memwb_d.dest      = exmem_q.dest;
    memwb_d.data      = exmem_q.mem_to_reg ? dm_rdata : exmem_q.result;
  end

  // Pipeline state; reset discards everything in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q    <= PC_RESET;
      ifid_q  <= '0;
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  // Register file write in WB; $0 is never written
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
    end else if (wb_we) begin
      rf_q[memwb_q.dest] <= memwb_q.data;
    end
  end

  // Data memory write in MEM; contents survive reset
  always_ff @(posedge clk_i) begin
    if (exmem_q.valid && exmem_q.mem_write) dm_q[exmem_q.result[7:2]] <= exmem_q.store;
  end

  assign unused_bits    = ^{exmem_q.result[31:8], exmem_q.result[1:0]};
  assign pc_o           = pc_q;
  assign retire_valid_o = memwb_q.valid;
  assign retire_pc_o    = memwb_q.pc;
  assign stall_o        = stall;
  assign flush_o        = branch_taken || jump_redirect;

endmodule
